// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Holds the return-owner enum, data/byte-enable widths and SRAM polarity.
package riscv_mem_pkg;

    localparam int BE_W   = 4;
    localparam int DWIDTH = 32;

    // SRAM control polarity (active-low chip select and write enable)
    localparam logic CSN_ON  = 1'b0;
    localparam logic CSN_OFF = 1'b1;
    localparam logic WEN_WR  = 1'b0;
    localparam logic WEN_RD  = 1'b1;

    // Which requester owns the SRAM read data arriving this cycle
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RET_I = 2'd1,
        RET_D = 2'd2
    } ret_owner_t;

    // Saturating 4-bit increment used by the starvation counter
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/riscv_mem_arb_pick.sv
// Grant decision between the fetch (I) and load/store (D) requesters.
// Build option RISCV_MEM_ARB_RR_EN selects round-robin on contention;
// otherwise D has priority unless the starvation flag hands the slot to I.
module riscv_mem_arb_pick (
    input  logic I_REQ,
    input  logic D_REQ,
`ifdef RISCV_MEM_ARB_RR_EN
    input  logic LAST_WIN_D,
`else
    input  logic STARVE,
`endif
    output logic I_GNT,
    output logic D_GNT
);

    logic w_i_first;

`ifdef RISCV_MEM_ARB_RR_EN
    // D won last time, so I goes first on the next collision
    assign w_i_first = LAST_WIN_D;
`else
    // I only overtakes D once it has been starved long enough
    assign w_i_first = STARVE;
`endif

    // One-hot (or zero) grant from the two request lines
    always_comb begin
        I_GNT = 1'b0;
        D_GNT = 1'b0;
        if (I_REQ && D_REQ) begin
            if (w_i_first) begin
                I_GNT = 1'b1;
            end else begin
                D_GNT = 1'b1;
            end
        end else if (I_REQ) begin
            I_GNT = 1'b1;
        end else if (D_REQ) begin
            D_GNT = 1'b1;
        end else begin
            I_GNT = 1'b0;
            D_GNT = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port SRAM between the RISC-V fetch and load/store sides.
// Per-cycle req/gnt handshake, read data steered back one cycle later.
// Optional macro RISCV_MEM_ARB_RR_EN: round-robin instead of D priority
// with an I starvation guard.
import riscv_mem_pkg::*;

module riscv_mem_arbiter #(
    parameter int AWIDTH     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic                I_REQ,
    input  logic [31:0]         I_ADDR,
    output logic                I_GNT,
    output logic                I_RVALID,
    output logic [DWIDTH-1:0]   I_RDATA,
    input  logic                D_REQ,
    input  logic                D_WEN,
    input  logic [BE_W-1:0]     D_BE,
    input  logic [31:0]         D_ADDR,
    input  logic [DWIDTH-1:0]   D_WDATA,
    output logic                D_GNT,
    output logic                D_RVALID,
    output logic [DWIDTH-1:0]   D_RDATA,
    output logic                M_CSN,
    output logic                M_WEN,
    output logic [BE_W-1:0]     M_BE,
    output logic [AWIDTH-1:0]   M_ADDR,
    output logic [DWIDTH-1:0]   M_DI,
    input  logic [DWIDTH-1:0]   M_DOUT
);

    logic       w_i_req;
    logic       w_d_req;
    logic       w_i_gnt;
    logic       w_d_gnt;
    ret_owner_t r_ret_owner;
    ret_owner_t w_ret_nxt;
    logic       w_unused_addr;

    // Requests are masked while reset is asserted so nothing reaches the SRAM
    assign w_i_req = I_REQ & RSTn;
    assign w_d_req = D_REQ & RSTn;

    // Byte-offset bits and bits above the SRAM depth are deliberately ignored
    assign w_unused_addr = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                             D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

`ifdef RISCV_MEM_ARB_RR_EN
    logic r_last_win_d;

    // Remember who won the most recent granted access (reset: I)
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_last_win_d <= 1'b0;
        end else if (w_d_gnt) begin
            r_last_win_d <= 1'b1;
        end else if (w_i_gnt) begin
            r_last_win_d <= 1'b0;
        end else begin
            r_last_win_d <= r_last_win_d;
        end
    end

    riscv_mem_arb_pick u_pick (
        .I_REQ      (w_i_req),
        .D_REQ      (w_d_req),
        .LAST_WIN_D (r_last_win_d),
        .I_GNT      (w_i_gnt),
        .D_GNT      (w_d_gnt)
    );
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic       w_starve;

    assign w_starve = (r_starve_cnt == STARVE_LIM);

    // Count consecutive cycles I asked and was refused; clear once served or idle
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_starve_cnt <= 4'd0;
        end else if (I_REQ && !w_i_gnt) begin
            r_starve_cnt <= sat_inc4(r_starve_cnt, STARVE_LIM);
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    riscv_mem_arb_pick u_pick (
        .I_REQ  (w_i_req),
        .D_REQ  (w_d_req),
        .STARVE (w_starve),
        .I_GNT  (w_i_gnt),
        .D_GNT  (w_d_gnt)
    );
`endif

    assign I_GNT = w_i_gnt;
    assign D_GNT = w_d_gnt;

    // Drive the SRAM port from whichever side won; park it idle otherwise
    always_comb begin
        M_CSN  = CSN_OFF;
        M_WEN  = WEN_RD;
        M_BE   = {BE_W{1'b0}};
        M_ADDR = {AWIDTH{1'b0}};
        M_DI   = {DWIDTH{1'b0}};
        if (w_i_gnt) begin
            M_CSN  = CSN_ON;
            M_WEN  = WEN_RD;
            M_ADDR = I_ADDR[AWIDTH+1:2];
        end else if (w_d_gnt) begin
            M_CSN  = CSN_ON;
            M_WEN  = D_WEN;
            M_BE   = D_BE;
            M_ADDR = D_ADDR[AWIDTH+1:2];
            M_DI   = D_WDATA;
        end else begin
            M_CSN  = CSN_OFF;
            M_WEN  = WEN_RD;
        end
    end

    // Next return owner: reads claim next cycle's SRAM output, writes do not
    always_comb begin
        w_ret_nxt = NONE;
        if (w_i_gnt) begin
            w_ret_nxt = RET_I;
        end else if (w_d_gnt && (D_WEN == WEN_RD)) begin
            w_ret_nxt = RET_D;
        end else begin
            w_ret_nxt = NONE;
        end
    end

    // Return owner register; reset drops any in-flight read
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_ret_owner <= NONE;
        end else begin
            r_ret_owner <= w_ret_nxt;
        end
    end

    // Steer SRAM read data to its owner; data is zero when not valid
    always_comb begin
        I_RVALID = 1'b0;
        I_RDATA  = {DWIDTH{1'b0}};
        D_RVALID = 1'b0;
        D_RDATA  = {DWIDTH{1'b0}};
        case (r_ret_owner)
            RET_I: begin
                I_RVALID = 1'b1;
                I_RDATA  = M_DOUT;
            end
            RET_D: begin
                D_RVALID = 1'b1;
                D_RDATA  = M_DOUT;
            end
            default: begin
                I_RVALID = 1'b0;
                D_RVALID = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed steps plus random
// traffic checked against a transaction-level model with its own memory image.
`timescale 1ns/1ps
module tb_riscv_mem_arbiter;

    localparam int AW     = 12;
    localparam int SMAX   = 4;
    localparam int DEPTH  = 1 << AW;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        I_REQ;
    logic [31:0] I_ADDR;
    logic        I_GNT;
    logic        I_RVALID;
    logic [31:0] I_RDATA;
    logic        D_REQ;
    logic        D_WEN;
    logic [3:0]  D_BE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic        D_GNT;
    logic        D_RVALID;
    logic [31:0] D_RDATA;
    logic        M_CSN;
    logic        M_WEN;
    logic [3:0]  M_BE;
    logic [AW-1:0] M_ADDR;
    logic [31:0] M_DI;
    logic [31:0] M_DOUT;

    riscv_mem_arbiter #(.AWIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
        .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_WEN(D_WEN), .D_BE(D_BE), .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA), .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_CSN(M_CSN), .M_WEN(M_WEN), .M_BE(M_BE), .M_ADDR(M_ADDR),
        .M_DI(M_DI), .M_DOUT(M_DOUT)
    );

    always #5 CLK = ~CLK;

    // Environment SRAM: one-cycle read latency, byte-enabled writes
    logic [31:0] sram [0:DEPTH-1];
    always @(posedge CLK) begin
        if (!M_CSN) begin
            if (!M_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (M_BE[b]) sram[M_ADDR][8*b +: 8] <= M_DI[8*b +: 8];
            end else begin
                M_DOUT <= sram[M_ADDR];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:DEPTH-1];
    int          checks = 0;
    int          errors = 0;
    int          denied = 0;      // consecutive refused I cycles
    bit          last_d = 1'b0;   // previous winner was D
    int          pend   = 0;      // 0 none, 1 I return due, 2 D return due
    logic [31:0] pend_data = 32'd0;
    logic        obs_i_gnt, obs_d_gnt;
    logic [31:0] obs_m_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [3:0] dbe,
                         input logic [31:0] da, input logic [31:0] dwd);
        logic eig, edg;
        logic [AW-1:0] wa;
        RSTn = rst; I_REQ = ir; I_ADDR = ia;
        D_REQ = dr; D_WEN = dw; D_BE = dbe; D_ADDR = da; D_WDATA = dwd;
        #4;
        eig = 1'b0; edg = 1'b0;
        if (rst) begin
            if (ir && dr) begin
`ifdef RISCV_MEM_ARB_RR_EN
                if (last_d) eig = 1'b1; else edg = 1'b1;
`else
                if (denied == SMAX) eig = 1'b1; else edg = 1'b1;
`endif
            end else if (ir) eig = 1'b1;
            else if (dr) edg = 1'b1;
        end
        obs_i_gnt  = I_GNT;
        obs_d_gnt  = D_GNT;
        obs_m_addr = 32'(M_ADDR);
        chk("i_gnt", 32'(I_GNT), 32'(eig));
        chk("d_gnt", 32'(D_GNT), 32'(edg));
        chk("m_csn", 32'(M_CSN), 32'(!(eig || edg)));
        if (eig) begin
            chk("m_wen_i", 32'(M_WEN), 32'd1);
            chk("m_be_i", 32'(M_BE), 32'd0);
            chk("m_addr_i", 32'(M_ADDR), 32'(ia[AW+1:2]));
        end else if (edg) begin
            chk("m_wen_d", 32'(M_WEN), 32'(dw));
            chk("m_be_d", 32'(M_BE), 32'(dbe));
            chk("m_addr_d", 32'(M_ADDR), 32'(da[AW+1:2]));
            chk("m_di_d", M_DI, dwd);
        end else begin
            chk("m_idle", {27'd0, M_WEN, M_BE}, 32'h10);
            chk("m_addr_idle", 32'(M_ADDR), 32'd0);
            chk("m_di_idle", M_DI, 32'd0);
        end
        chk("i_rvalid", 32'(I_RVALID), 32'(pend == 1));
        chk("i_rdata", I_RDATA, (pend == 1) ? pend_data : 32'd0);
        chk("d_rvalid", 32'(D_RVALID), 32'(pend == 2));
        chk("d_rdata", D_RDATA, (pend == 2) ? pend_data : 32'd0);
        // advance the model
        pend = 0;
        if (eig) begin
            pend = 1;
            pend_data = ref_mem[ia[AW+1:2]];
        end else if (edg) begin
            wa = da[AW+1:2];
            if (dw) begin
                pend = 2;
                pend_data = ref_mem[wa];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) ref_mem[wa][8*b +: 8] = dwd[8*b +: 8];
            end
        end
        if (!rst) denied = 0;
        else if (ir && !eig) denied = (denied + 1 > SMAX) ? SMAX : denied + 1;
        else denied = 0;
        if (!rst) last_d = 1'b0;
        else if (edg) last_d = 1'b1;
        else if (eig) last_d = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic rst);
        cycle(rst, 1'b0, 32'd0, 1'b0, 1'b1, 4'h0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        eexp;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom();
            sram[i] = r;
            ref_mem[i] = r;
        end
        sram[0] = 32'h1111_1111; ref_mem[0] = 32'h1111_1111;
        sram[1] = 32'h2222_2222; ref_mem[1] = 32'h2222_2222;
        M_DOUT = 32'd0;
        RSTn = 1'b0; I_REQ = 1'b0; I_ADDR = 32'd0; D_REQ = 1'b0; D_WEN = 1'b1;
        D_BE = 4'h0; D_ADDR = 32'd0; D_WDATA = 32'd0;
        @(posedge CLK);
        #1;

        // 1. reset held with both requesting
        for (int k = 0; k < 3; k++)
            cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 4'hF, 32'h4, 32'd0);
        chk("t1_i_rvalid", 32'(I_RVALID), 32'd0);
        chk("t1_d_rvalid", 32'(D_RVALID), 32'd0);
        chk("t1_rdata", I_RDATA | D_RDATA, 32'd0);
        idle(1'b1);

        // 2. D write then read back
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
        chk("t2_wr_no_rvalid", 32'(D_RVALID), 32'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 4'h0, 32'h10, 32'd0);
        chk("t2_rd_rvalid", 32'(D_RVALID), 32'd1);
        chk("t2_rd_rdata", D_RDATA, 32'hDEAD_BEEF);
        idle(1'b1);

        // 4. interleaved I then D returns
        cycle(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 4'h0, 32'd0, 32'd0);
        chk("t4_i_rvalid", 32'(I_RVALID), 32'd1);
        chk("t4_i_rdata", I_RDATA, 32'h1111_1111);
        chk("t4_d_quiet", 32'(D_RVALID), 32'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 4'h0, 32'h4, 32'd0);
        chk("t4_d_rvalid", 32'(D_RVALID), 32'd1);
        chk("t4_d_rdata", D_RDATA, 32'h2222_2222);
        chk("t4_i_quiet", 32'(I_RVALID), 32'd0);
        idle(1'b1);

        // 5. address wrap aliases onto 0x10
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h4010, 32'hCAFE_F00D);
        chk("t5_m_addr", obs_m_addr, 32'h004);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 4'h0, 32'h10, 32'd0);
        chk("t5_alias_rdata", D_RDATA, 32'hCAFE_F00D);
        idle(1'b1);

        // 3 / 6. continuous contention from a fresh reset
        idle(1'b0);
        idle(1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b1, $urandom() & 32'h0000_003C, 1'b1, 1'b1, 4'h0,
                  $urandom() & 32'h0000_003C, 32'd0);
`ifdef RISCV_MEM_ARB_RR_EN
            eexp = ((k % 2) == 1);
`else
            eexp = ((k % (SMAX + 1)) == SMAX);
`endif
            chk("contend_i", 32'(obs_i_gnt), 32'(eexp));
            chk("contend_d", 32'(obs_d_gnt), 32'(!eexp));
        end

        // random traffic, occasional reset, requests sometimes dropped
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 39) != 0), 1'($urandom()), $urandom() & 32'hF000_003F,
                  1'($urandom()), 1'($urandom()), 4'($urandom()),
                  $urandom() & 32'hF000_403F, $urandom());
        end
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
